// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the button event generator: FSM state codes and the
// default thresholds reused by every button instance.
package button_event_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

  localparam int LONG_CYCLES_DEF   = 100;
  localparam int REPEAT_CYCLES_DEF = 25;
  localparam int CNT_W_DEF         = 16;

endpackage

// File: rtl/button_event_gen_if.sv
// Button-side bundle: debounced level in, event strobes and held level out.
interface button_event_gen_if;
  logic pb_in;
  logic press_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    output pb_in,
    input  press_pulse, short_pulse, long_pulse, repeat_pulse, held
  );

  modport slave (
    input  pb_in,
    output press_pulse, short_pulse, long_pulse, repeat_pulse, held
  );
endinterface

// File: rtl/button_event_gen_hold.sv
// Hold-length counter with clear/enable and a terminal compare against a
// threshold supplied by the FSM (term_o is high when cnt == thresh_i-1).
module btn_hold_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             term_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == (thresh_i - ONE));

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press/short/long/repeat strobes.
// Optional auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  button_event_gen_if.slave btn_if
);

  localparam logic [CNT_W-1:0] LONG_TH   = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_TH = CNT_W'(REPEAT_CYCLES);

  btn_state_e       state_q;
  logic             press_q;
  logic             short_q;
  logic             long_q;
  logic             held_q;
`ifdef BTN_AUTOREPEAT_EN
  logic             repeat_q;
`endif

  logic             pb_s;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic [CNT_W-1:0] thresh_s;
  logic             term_s;

  assign pb_s = btn_if.pb_in;

  // The single counter times the long threshold in PRESSED and the repeat period in HELD.
  always_comb begin
    cnt_clr_s = 1'b1;
    cnt_en_s  = 1'b0;
    thresh_s  = LONG_TH;
    case (state_q)
      ST_IDLE: begin
        if (pb_s) begin
          cnt_clr_s = 1'b0;
          cnt_en_s  = 1'b1;
        end else begin
          cnt_clr_s = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (pb_s && !term_s) begin
          cnt_clr_s = 1'b0;
          cnt_en_s  = 1'b1;
        end else begin
          cnt_clr_s = 1'b1;
        end
      end
      ST_HELD: begin
        thresh_s = REPEAT_TH;
`ifdef BTN_AUTOREPEAT_EN
        if (pb_s && !term_s) begin
          cnt_clr_s = 1'b0;
          cnt_en_s  = 1'b1;
        end else begin
          cnt_clr_s = 1'b1;
        end
`else
        cnt_clr_s = 1'b1;
`endif
      end
      default: begin
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  btn_hold_counter #(
    .CNT_W (CNT_W)
  ) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr_s),
    .en_i     (cnt_en_s),
    .thresh_i (thresh_s),
    .term_o   (term_s)
  );

  // Event FSM; every strobe defaults low so each is exactly one cycle wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      press_q  <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_q <= 1'b0;
`endif
    end else begin
      press_q  <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (pb_s) begin
            state_q <= ST_PRESSED;
            press_q <= 1'b1;
            held_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            held_q  <= 1'b0;
          end
        end
        ST_PRESSED: begin
          if (!pb_s) begin
            state_q <= ST_IDLE;
            short_q <= 1'b1;
            held_q  <= 1'b0;
          end else if (term_s) begin
            state_q <= ST_HELD;
            long_q  <= 1'b1;
            held_q  <= 1'b1;
          end else begin
            state_q <= ST_PRESSED;
            held_q  <= 1'b1;
          end
        end
        ST_HELD: begin
          if (!pb_s) begin
            state_q <= ST_IDLE;
            held_q  <= 1'b0;
          end else begin
            state_q <= ST_HELD;
            held_q  <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            repeat_q <= term_s;
`endif
          end
        end
        default: begin
          // Unused encoding: fall back to IDLE silently.
          state_q <= ST_IDLE;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign btn_if.press_pulse  = press_q;
  assign btn_if.short_pulse  = short_q;
  assign btn_if.long_pulse   = long_q;
  assign btn_if.held         = held_q;
`ifdef BTN_AUTOREPEAT_EN
  assign btn_if.repeat_pulse = repeat_q;
`else
  assign btn_if.repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Observed vector order: {press, short, long, repeat, held}.
module tb_button_event_gen;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  button_event_gen_if bus_if ();

  button_event_gen #(
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .CNT_W         (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive pb_in, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic v);
    bus_if.pb_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst = 1'b1;
    bus_if.pb_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {bus_if.press_pulse, bus_if.short_pulse, bus_if.long_pulse, bus_if.repeat_pulse, bus_if.held};
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", obs, 5'b00000);
    end
    rst = 1'b0;
    #1;
    obs = {bus_if.press_pulse, bus_if.short_pulse, bus_if.long_pulse, bus_if.repeat_pulse, bus_if.held};
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL reset_exit: got %b expected %b", obs, 5'b00000);
    end
    step(1'b1);
    obs = {bus_if.press_pulse, bus_if.short_pulse, bus_if.long_pulse, bus_if.repeat_pulse, bus_if.held};
    checks++;
    if (obs !== 5'b10001) begin
      errors++;
      $display("FAIL reset_first_press: got %b expected %b", obs, 5'b10001);
    end
    step(1'b0);
    obs = {bus_if.press_pulse, bus_if.short_pulse, bus_if.long_pulse, bus_if.repeat_pulse, bus_if.held};
    checks++;
    if (obs !== 5'b01000) begin
      errors++;
      $display("FAIL reset_first_release: got %b expected %b", obs, 5'b01000);
    end
    step(1'b0);
  endtask

  // Hold for k edges then release; check every cycle including two after release.
  task automatic test_hold(input int k, input string name);
    logic [4:0] obs;
    logic [4:0] exp;
    for (int e = 1; e <= k + 2; e++) begin
      step(e <= k);
      exp = 5'b00000;
      if (e <= k) begin
        exp[0] = 1'b1;
        if (e == 1) exp[4] = 1'b1;
        if (e == 8) exp[2] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
        if (e > 8 && ((e - 8) % 4) == 0) exp[1] = 1'b1;
`endif
      end else if (e == k + 1 && k < 8) begin
        exp[3] = 1'b1;
      end else begin
        exp = 5'b00000;
      end
      obs = {bus_if.press_pulse, bus_if.short_pulse, bus_if.long_pulse, bus_if.repeat_pulse, bus_if.held};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s edge %0d: got %b expected %b", name, e, obs, exp);
      end
    end
  endtask

  task automatic test_short_press();
    test_hold(3, "short_press");
  endtask

  task automatic test_boundary();
    test_hold(7, "boundary_7");
    test_hold(8, "boundary_8");
  endtask

  task automatic test_autorepeat();
    test_hold(20, "autorepeat_20");
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] obs;
    for (int e = 1; e <= 4; e++) step(1'b1);
    obs = {bus_if.press_pulse, bus_if.short_pulse, bus_if.long_pulse, bus_if.repeat_pulse, bus_if.held};
    checks++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL mid_hold_before_rst: got %b expected %b", obs, 5'b00001);
    end
    rst = 1'b1;
    #1;
    obs = {bus_if.press_pulse, bus_if.short_pulse, bus_if.long_pulse, bus_if.repeat_pulse, bus_if.held};
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL mid_hold_rst_async: got %b expected %b", obs, 5'b00000);
    end
    for (int e = 0; e < 10; e++) begin
      step(1'b1);
      obs = {bus_if.press_pulse, bus_if.short_pulse, bus_if.long_pulse, bus_if.repeat_pulse, bus_if.held};
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL mid_hold_in_rst cycle %0d: got %b expected %b", e, obs, 5'b00000);
      end
    end
    rst = 1'b0;
    step(1'b1);
    obs = {bus_if.press_pulse, bus_if.short_pulse, bus_if.long_pulse, bus_if.repeat_pulse, bus_if.held};
    checks++;
    if (obs !== 5'b10001) begin
      errors++;
      $display("FAIL mid_hold_new_press: got %b expected %b", obs, 5'b10001);
    end
    step(1'b0);
    obs = {bus_if.press_pulse, bus_if.short_pulse, bus_if.long_pulse, bus_if.repeat_pulse, bus_if.held};
    checks++;
    if (obs !== 5'b01000) begin
      errors++;
      $display("FAIL mid_hold_new_short: got %b expected %b", obs, 5'b01000);
    end
    step(1'b0);
  endtask

  task automatic test_rapid_taps();
    logic [4:0] obs;
    for (int t = 0; t < 4; t++) begin
      step(1'b1);
      obs = {bus_if.press_pulse, bus_if.short_pulse, bus_if.long_pulse, bus_if.repeat_pulse, bus_if.held};
      checks++;
      if (obs !== 5'b10001) begin
        errors++;
        $display("FAIL tap%0d_press: got %b expected %b", t, obs, 5'b10001);
      end
      step(1'b0);
      obs = {bus_if.press_pulse, bus_if.short_pulse, bus_if.long_pulse, bus_if.repeat_pulse, bus_if.held};
      checks++;
      if (obs !== 5'b01000) begin
        errors++;
        $display("FAIL tap%0d_short: got %b expected %b", t, obs, 5'b01000);
      end
    end
    step(1'b0);
    obs = {bus_if.press_pulse, bus_if.short_pulse, bus_if.long_pulse, bus_if.repeat_pulse, bus_if.held};
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL taps_idle: got %b expected %b", obs, 5'b00000);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus_if.pb_in = 1'b0;
    test_reset();
    test_short_press();
    test_boundary();
    test_autorepeat();
    test_reset_mid_hold();
    test_rapid_taps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
